// File: rtl/seg_scan_pkg.sv
// ---------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the seven-segment scan decoder: active-high glyph
// patterns (bit order gfedcba), scan-filter state encoding and digit count.
// ---------------------------------------------------------------------------
package seg_scan_pkg;

  localparam int NUM_DIGITS = 4;

  // Active-high segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D; // with segment a lit
  localparam logic [6:0] SEG_7     = 7'h07; // without segment f
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F; // with segment d lit
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C; // lowercase b
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E; // lowercase d
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    HOLD
  } state_t;

endpackage

// File: rtl/seg_scan_decoder_seg7_to_hex.sv
// ---------------------------------------------------------------------------
// seg7_to_hex
// Combinational decode of an active-high seven-segment pattern back to the
// hex nibble it displays. Blank and illegal patterns both return nibble 0
// and are told apart by the blank/err flags.
//
// Ports:
//   pattern  in   7  active-high segments, bit0 = a ... bit6 = g
//   nibble   out  4  decoded hex value (0 when blank or illegal)
//   blank    out  1  all segments off
//   err      out  1  pattern is not one of the sixteen hex glyphs
// ---------------------------------------------------------------------------
module seg7_to_hex
  import seg_scan_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err
);

  // NOTE: every output gets a default before the case so no path through the
  // block leaves a value unassigned; otherwise synthesis infers a latch.
  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b0;
    case (pattern)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_decoder.sv
// ---------------------------------------------------------------------------
// seg_scan_decoder
// Receive-side monitor for a multiplexed 4-digit seven-segment bus. Each
// scan step (select + segments) must be stable for STABLE_CYCLES samples
// before it is captured; captured glyphs are decoded into a staging frame,
// and the frame is published once all four digits have been seen.
//
// Optional build macro:
//   SEG_SYNC_EN  two-flop synchronizers on seg_n / sel_n (asynchronous source)
//
// Ports:
//   clock        in   1   system clock
//   reset        in   1   asynchronous, active-low
//   seg_n        in   7   segment lines, active-low, bit0 = a ... bit6 = g
//   sel_n        in   4   digit select, active-low one-hot, bit0 = digit 0
//   frame_data   out  16  last complete frame {d3,d2,d1,d0}
//   frame_valid  out  1   one-cycle pulse when frame outputs update
//   frame_blank  out  4   per digit: glyph was blank
//   frame_err    out  4   per digit: glyph was not a legal hex pattern
//   sel_err      out  1   one-cycle pulse: settled select not one-hot
// ---------------------------------------------------------------------------
module seg_scan_decoder
  import seg_scan_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [6:0]                seg_n,
  input  logic [NUM_DIGITS-1:0]     sel_n,
  output logic [4*NUM_DIGITS-1:0]   frame_data,
  output logic                      frame_valid,
  output logic [NUM_DIGITS-1:0]     frame_blank,
  output logic [NUM_DIGITS-1:0]     frame_err,
  output logic                      sel_err
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STABLE_CNT = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX    = '1;

  // -------------------------------------------------------------------------
  // Input conditioning
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] sel_s;
  logic [6:0]            seg_s;

`ifdef SEG_SYNC_EN
  logic [NUM_DIGITS-1:0] sel_meta;
  logic [6:0]            seg_meta;

  // Reset to all-ones: the idle (nothing driven) level of an active-low bus.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sel_meta <= '1;
      sel_s    <= '1;
      seg_meta <= '1;
      seg_s    <= '1;
    end else begin
      sel_meta <= sel_n;
      sel_s    <= sel_meta;
      seg_meta <= seg_n;
      seg_s    <= seg_meta;
    end
  end
`else
  assign sel_s = sel_n;
  assign seg_s = seg_n;
`endif

  // -------------------------------------------------------------------------
  // Select decode and glyph decode of the current sample
  // -------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] sel_act;
  logic                  sel_onehot;
  logic [1:0]            idx;
  logic [3:0]            dec_nibble;
  logic                  dec_blank;
  logic                  dec_err;

  assign sel_act    = ~sel_s;
  assign sel_onehot = (sel_act != '0) && ((sel_act & (sel_act - 1'b1)) == '0);

  // Only meaningful when sel_onehot is true.
  always_comb begin
    idx = 2'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sel_act[i]) idx = 2'(i);
    end
  end

  seg7_to_hex u_dec (
    .pattern (~seg_s),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .err     (dec_err)
  );

  // -------------------------------------------------------------------------
  // Scan filter FSM
  // -------------------------------------------------------------------------
  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [NUM_DIGITS-1:0] prev_sel;
  logic [6:0]            prev_seg;
  logic                  same;
  logic                  settled;
  logic                  capture;
  logic                  sel_err_d;

  assign same = (sel_s == prev_sel) && (seg_s == prev_seg);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    settled = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_d   = CW'(1);
        state_d = SETTLE;
      end
      SETTLE: begin
        if (same) cnt_d = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        else      cnt_d = CW'(1);
        if (cnt_d == STABLE_CNT) begin
          settled = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (!same) begin
          cnt_d = CW'(1);
          // A one-sample filter accepts the new value on its first sample.
          if (STABLE_CNT == CW'(1)) settled = 1'b1;
          else                      state_d = SETTLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CW'(1);
      end
    endcase
  end

  assign capture   = settled && sel_onehot;
  assign sel_err_d = settled && !sel_onehot;

  // -------------------------------------------------------------------------
  // Staging frame: next-state with the new digit merged in
  // -------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] stage_data, stage_data_d;
  logic [NUM_DIGITS-1:0]   stage_blank, stage_blank_d;
  logic [NUM_DIGITS-1:0]   stage_err, stage_err_d;
  logic [NUM_DIGITS-1:0]   mask, mask_d;

  always_comb begin
    stage_data_d  = stage_data;
    stage_blank_d = stage_blank;
    stage_err_d   = stage_err;
    mask_d        = mask;
    if (capture) begin
      stage_data_d[{idx, 2'b00} +: 4] = dec_nibble;
      stage_blank_d[idx]              = dec_blank;
      stage_err_d[idx]                = dec_err;
      mask_d[idx]                     = 1'b1;
    end
  end

  // NOTE: all state, including the staging slots, is reset so a reset
  // mid-frame cannot leak stale digits into the next published frame.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= CW'(1);
      prev_sel    <= '1;
      prev_seg    <= '1;
      stage_data  <= '0;
      stage_blank <= '0;
      stage_err   <= '0;
      mask        <= '0;
      frame_data  <= '0;
      frame_blank <= '0;
      frame_err   <= '0;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      prev_sel    <= sel_s;
      prev_seg    <= seg_s;
      stage_data  <= stage_data_d;
      stage_blank <= stage_blank_d;
      stage_err   <= stage_err_d;
      sel_err     <= sel_err_d;
      frame_valid <= 1'b0;
      if (capture && (mask_d == '1)) begin
        // Publish including the digit captured on this same edge.
        frame_data  <= stage_data_d;
        frame_blank <= stage_blank_d;
        frame_err   <= stage_err_d;
        frame_valid <= 1'b1;
        mask        <= '0;
      end else begin
        mask        <= mask_d;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  err;
  } frame_t;

  typedef struct {
    logic [6:0] seg_n;
    logic [3:0] nib;
    logic       blank;
    logic       err;
  } vec_t;

  logic        clock;
  logic        reset;
  logic [6:0]  seg_n;
  logic [3:0]  sel_n;
  logic [15:0] frame_data;
  logic        frame_valid;
  logic [3:0]  frame_blank;
  logic [3:0]  frame_err;
  logic        sel_err;

  int     assertions = 0;
  int     failures   = 0;
  int     sel_err_count = 0;
  logic   prev_fv = 1'b0;
  frame_t exp_q[$];

  seg_scan_decoder #(.STABLE_CYCLES(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .seg_n       (seg_n),
    .sel_n       (sel_n),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_blank (frame_blank),
    .frame_err   (frame_err),
    .sel_err     (sel_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every published frame must match the oldest expectation.
  always @(negedge clock) begin
    if (reset) begin
      if (sel_err) sel_err_count++;
      if (frame_valid) begin
        check("frame_valid_width", 32'(prev_fv), 32'd0);
        if (exp_q.size() == 0) begin
          assertions++;
          failures++;
          $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", frame_data);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("frame_data",  32'(frame_data),  32'(e.data));
          check("frame_blank", 32'(frame_blank), 32'(e.blank));
          check("frame_err",   32'(frame_err),   32'(e.err));
        end
      end
    end
    prev_fv = frame_valid;
  end

  // Called on a falling edge; returns on a falling edge n cycles later.
  task automatic hold(input logic [3:0] s, input logic [6:0] g, input int n);
    sel_n = s;
    seg_n = g;
    repeat (n) @(negedge clock);
  endtask

  task automatic scan(input logic [6:0] g0, input logic [6:0] g1,
                      input logic [6:0] g2, input logic [6:0] g3, input frame_t e);
    hold(4'b1110, g0, 8);
    hold(4'b1101, g1, 8);
    hold(4'b1011, g2, 8);
    exp_q.push_back(e);
    hold(4'b0111, g3, 8);
  endtask

  vec_t   tbl[20];
  frame_t acc;
  int     err_before;

  initial begin
    tbl[0]  = '{7'h40, 4'h0, 1'b0, 1'b0};
    tbl[1]  = '{7'h79, 4'h1, 1'b0, 1'b0};
    tbl[2]  = '{7'h24, 4'h2, 1'b0, 1'b0};
    tbl[3]  = '{7'h30, 4'h3, 1'b0, 1'b0};
    tbl[4]  = '{7'h19, 4'h4, 1'b0, 1'b0};
    tbl[5]  = '{7'h12, 4'h5, 1'b0, 1'b0};
    tbl[6]  = '{7'h02, 4'h6, 1'b0, 1'b0};
    tbl[7]  = '{7'h78, 4'h7, 1'b0, 1'b0};
    tbl[8]  = '{7'h00, 4'h8, 1'b0, 1'b0};
    tbl[9]  = '{7'h10, 4'h9, 1'b0, 1'b0};
    tbl[10] = '{7'h08, 4'hA, 1'b0, 1'b0};
    tbl[11] = '{7'h03, 4'hB, 1'b0, 1'b0};
    tbl[12] = '{7'h46, 4'hC, 1'b0, 1'b0};
    tbl[13] = '{7'h21, 4'hD, 1'b0, 1'b0};
    tbl[14] = '{7'h06, 4'hE, 1'b0, 1'b0};
    tbl[15] = '{7'h0E, 4'hF, 1'b0, 1'b0};
    tbl[16] = '{7'h7F, 4'h0, 1'b1, 1'b0}; // blank
    tbl[17] = '{7'h7E, 4'h0, 1'b0, 1'b1}; // only a lit
    tbl[18] = '{7'h18, 4'h0, 1'b0, 1'b1}; // 9 without d
    tbl[19] = '{7'h58, 4'h0, 1'b0, 1'b1}; // 7 with f

    reset = 1'b0;
    sel_n = 4'b1110;
    seg_n = 7'h79;
    repeat (3) @(negedge clock);
    check("rst_frame_data",  32'(frame_data),  32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_frame_blank", 32'(frame_blank), 32'h0);
    check("rst_frame_err",   32'(frame_err),   32'h0);
    check("rst_sel_err",     32'(sel_err),     32'h0);
    reset = 1'b1;

    // Basic scan "1234".
    scan(7'h79, 7'h24, 7'h30, 7'h19, '{16'h4321, 4'h0, 4'h0});

    // Digit 2 blank.
    scan(7'h79, 7'h24, 7'h7F, 7'h19, '{16'h4021, 4'b0100, 4'h0});

    // Two digits selected: one sel_err, no frame.
    err_before = sel_err_count;
    hold(4'b1100, 7'h79, 8);
    check("sel_err_pulses", 32'(sel_err_count - err_before), 32'd1);

    // Glitch shorter than the filter during digit 1 hold.
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 5);
    hold(4'b1101, 7'h00, 2);
    hold(4'b1101, 7'h24, 8);
    hold(4'b1011, 7'h30, 8);
    exp_q.push_back('{16'h4321, 4'h0, 4'h0});
    hold(4'b0111, 7'h19, 8);
    check("glitch_frame_data", 32'(frame_data), 32'h4321);
    check("glitch_frame_err",  32'(frame_err),  32'h0);

    // Reset after digits 0,1 captured; restart from digit 2 so a surviving
    // mask would complete a frame early.
    hold(4'b1110, 7'h79, 8);
    hold(4'b1101, 7'h24, 8);
    reset = 1'b0;
    sel_n = 4'b1011;
    seg_n = 7'h30;
    repeat (2) @(negedge clock);
    check("midrst_frame_data",  32'(frame_data),  32'h0);
    check("midrst_frame_valid", 32'(frame_valid), 32'h0);
    check("midrst_frame_blank", 32'(frame_blank), 32'h0);
    reset = 1'b1;
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h19, 8);
    hold(4'b1110, 7'h79, 8);
    check("postrst_no_frame", 32'(frame_data), 32'h0);
    exp_q.push_back('{16'h4321, 4'h0, 4'h0});
    hold(4'b1101, 7'h24, 8);

    // Digit 3 recaptured before the frame completes.
    hold(4'b1011, 7'h30, 8);
    hold(4'b0111, 7'h19, 8);
    hold(4'b0111, 7'h12, 8);
    hold(4'b1101, 7'h24, 8);
    exp_q.push_back('{16'h5321, 4'h0, 4'h0});
    hold(4'b1110, 7'h79, 8);

    // Glyph table: every four entries form one frame.
    acc = '{16'h0, 4'h0, 4'h0};
    for (int i = 0; i < 20; i++) begin
      int d;
      d = i % 4;
      acc.data[4*d +: 4] = tbl[i].nib;
      acc.blank[d]       = tbl[i].blank;
      acc.err[d]         = tbl[i].err;
      if (d == 3) exp_q.push_back(acc);
      hold(~(4'b0001 << d), tbl[i].seg_n, 8);
    end
    repeat (4) @(negedge clock);

    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("sel_err_total",  32'(sel_err_count), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side decoder for the multiplexed seven-segment display bus driven by the clock core's display scanner. Samples the active-low segment lines and active-low one-hot digit select, filters scan transitions, decodes each settled glyph back to a hex nibble, and publishes a complete 4-digit frame once every digit has been captured. Used as an on-chip loopback monitor and as the display-bus checker in the system bench.

## Interface
- STABLE_CYCLES, 4: consecutive identical samples (select and segments) required before a capture; legal range 1..255.
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low
- seg_n  input  7  segment lines, active-low; bit0=a … bit6=g
- sel_n  input  4  digit select, active-low one-hot; bit0 = digit 0 = least-significant nibble
- frame_data  output  16  last complete frame, {d3,d2,d1,d0}
- frame_valid  output  1  one-cycle pulse when frame_data/frame_blank/frame_err update
- frame_blank  output  4  per digit: captured glyph was all segments off
- frame_err  output  4  per digit: captured glyph not a legal 0–F pattern
- sel_err  output  1  one-cycle pulse: select settled with zero or more than one digit active

## Operation
- Inputs pass through the optional synchronizer (see Configuration) to give sel_s/seg_s.
- States: IDLE, SETTLE, HOLD.
  - IDLE: stable counter = 1 on every cycle; go SETTLE next cycle.
  - SETTLE: if sel_s and seg_s equal previous sample, counter increments, else counter reloads 1. On counter reaching STABLE_CYCLES: if sel_s is one-hot-low, capture; otherwise pulse sel_err. Go HOLD.
  - HOLD: stay while sel_s and seg_s unchanged; any change returns to SETTLE with counter = 1.
- STABLE_CYCLES = 1 captures on the first sample after a change.
- Capture: nibble = decoded glyph (standard patterns, 6 with a lit, 7 without f, 9 with d, b/d lowercase, A C E F uppercase); blank → nibble 0, blank bit set; illegal → nibble 0, err bit set. Written to staging slot idx; capture mask bit idx set.
- Re-capture of an already-captured digit before frame completion overwrites its slot.
- When the mask becomes 4'hF: staging copied to frame outputs (including the digit captured on that edge), frame_valid pulses, mask cleared.
- Counter saturates; width = $clog2(STABLE_CYCLES+1).

## Timing
- Reset: frame_data 16'h0000, frame_valid 0, frame_blank 4'h0, frame_err 4'h0, sel_err 0, mask 0, state IDLE, staging 0.
- Input change to capture: STABLE_CYCLES cycles after the first sample of the new value (+2 with SEG_SYNC_EN).
- frame_valid and frame outputs update on the same edge as the final digit capture; frame_valid high exactly one cycle.
- sel_err and frame_valid can coincide only if not both from one capture event (they cannot; a bad select never completes a frame).
- Reset mid-frame discards the partial mask and staging; no frame_valid until four fresh captures.
- Segment glitch shorter than STABLE_CYCLES during HOLD: forces re-settle; recaptured value identical, no spurious frame.

## Configuration
- SEG_SYNC_EN defined: seg_n and sel_n each pass through a two-flop synchronizer (reset to all-ones), adding 2 cycles of latency; required when the source is asynchronous.
- Undefined: inputs used directly; source must be synchronous to clock.

## Structure
- Shared package seg_scan_pkg: glyph constants SEG_0..SEG_F (active-high, gfedcba), SEG_BLANK, state enum {IDLE, SETTLE, HOLD}, NUM_DIGITS = 4.
- Sub-module seg7_to_hex: combinational 7-bit pattern → {nibble, blank, err}; also reused by the scanner's checker.

## Test plan
- Scan digits 0..3 with seg_n 7'h79,7'h24,7'h30,7'h19 ("1","2","3","4"), 8 cycles each, STABLE_CYCLES=4 -> one frame_valid, frame_data 16'h4321, blank/err 0.
- Same scan, digit 2 held at seg_n 7'h7F -> frame_data 16'h4021, frame_blank 4'b0100.
- sel_n 4'b1100 held 8 cycles -> one sel_err pulse, no capture, no frame_valid.
- Digit 1 pattern with 2-cycle glitch to 7'h00 mid-hold -> frame_data unchanged 16'h4321, err 0.
- Reset asserted after digits 0,1 captured, then full scan -> first frame_valid only after four new captures; outputs 0 during reset.
- Digit 3 captured twice (7'h19 then 7'h12 "5") before digit 0 -> frame_data 16'h5321.
